fp_result_queue: RTL and testbench

- Sits directly downstream of the FP ALU result selector. It consumes the selected 32-bit result z, the compare flags gr/ls/eq and the op code that produced them.
- Each accepted result is classified as IEEE-754 single precision and stored in a small first-word-fall-through FIFO.
- Entries are presented to the consumer (register file writeback / host interface) under a valid/ready handshake.
- Decouples the combinational ALU datapath from a consumer that may stall.

---
 rtl/fp_result_queue.sv | 108 ++++++++++
 tb/tb_fp_result_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_queue.sv
// fp_result_queue: classifies FP ALU results as IEEE-754 single precision and
// buffers them in a small first-word-fall-through FIFO with valid/ready output.
module fp_result_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [31:0]   z,
    input  logic          gr,
    input  logic          ls,
    input  logic          eq,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_op,
    output logic [31:0]   out_z,
    output logic [2:0]    out_cmp,
    output logic [4:0]    out_class,
    output logic [AW:0]   count
);

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] z;
        logic [2:0]  cmp;
        logic [4:0]  cls;   // {illegal,nan,inf,zero,subnormal}
    } entry_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    entry_t          mem [DEPTH];
    entry_t          wr_ent;
    entry_t          head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop;
    logic [7:0]      e;
    logic [22:0]     m;

    // Full/empty come from the occupancy counter; pointers alone are ambiguous.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign e = z[30:23];
    assign m = z[22:0];

    // Classify the incoming word and build the entry to be stored.
    always_comb begin
        wr_ent    = '0;
        wr_ent.op = op;
        wr_ent.z  = z;
        if (op[2]) begin
            // compare op keeps its flags; reserved ops are flagged illegal
            // but still carry z and flags through untouched
            wr_ent.cmp = {gr, ls, eq};
            if (op[1:0] != 2'b00)
                wr_ent.cls = 5'b10000;
        end else begin
            // arithmetic ops: flags are meaningless, class from exponent/fraction
            wr_ent.cmp = 3'b000;
            if (e == 8'hFF)
                wr_ent.cls = (m != '0) ? 5'b01000 : 5'b00100;
            else if (e == 8'h00)
                wr_ent.cls = (m != '0) ? 5'b00001 : 5'b00010;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_ent;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at 2**AW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Fall-through head; outputs forced to zero while empty.
    always_comb begin
        head = '0;
        if (out_valid)
            head = mem[rd_ptr];
    end

    assign out_op    = head.op;
    assign out_z     = head.z;
    assign out_cmp   = head.cmp;
    assign out_class = head.cls;

endmodule

// File: tb/tb_fp_result_queue.sv
// tb_fp_result_queue: directed stimulus with a queue-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_fp_result_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          in_valid = 0;
    logic          in_ready;
    logic [2:0]    op = 0;
    logic [31:0]   z = 0;
    logic          gr = 0, ls = 0, eq = 0;
    logic          out_valid;
    logic          out_ready = 0;
    logic [2:0]    out_op;
    logic [31:0]   out_z;
    logic [2:0]    out_cmp;
    logic [4:0]    out_class;
    logic [AW:0]   count;

    int n_cmp  = 0;
    int n_fail = 0;

    fp_result_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .z(z), .gr(gr), .ls(ls), .eq(eq),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_z(out_z), .out_cmp(out_cmp),
        .out_class(out_class), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] z;
        logic [2:0]  cmp;
        logic [4:0]  cls;
    } ent_t;

    ent_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference classification straight from the IEEE-754 field definitions.
    function automatic logic [4:0] ref_class(input logic [2:0] o, input logic [31:0] w);
        int exp_f;
        int frac;
        if (o > 3'd4) return 5'b10000;
        if (o == 3'd4) return 5'b00000;
        exp_f = int'(w[30:23]);
        frac  = int'(w[22:0]);
        if (exp_f == 255) return (frac != 0) ? 5'b01000 : 5'b00100;
        if (exp_f == 0)   return (frac != 0) ? 5'b00001 : 5'b00010;
        return 5'b00000;
    endfunction

    // Model update on each rising edge from the stable inputs.
    always @(posedge clk) begin
        if (rst_n) begin
            bit do_push, do_pop;
            ent_t en;
            do_push = in_valid && (q.size() != DEPTH);
            do_pop  = (q.size() != 0) && out_ready;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                en.op  = op;
                en.z   = z;
                en.cmp = (op <= 3'd3) ? 3'b000 : {gr, ls, eq};
                en.cls = ref_class(op, z);
                q.push_back(en);
            end
        end
    end

    // Reset empties the model immediately, without a clock.
    always @(negedge rst_n) q.delete();

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_count", 32'(count), 32'(q.size()));
            chk("m_in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
            chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("m_out_op", 32'(out_op), 32'(q[0].op));
                chk("m_out_z", out_z, q[0].z);
                chk("m_out_cmp", 32'(out_cmp), 32'(q[0].cmp));
                chk("m_out_class", 32'(out_class), 32'(q[0].cls));
            end else begin
                chk("m_empty_outs", {out_op, out_cmp, out_class}, 32'd0);
                chk("m_empty_z", out_z, 32'd0);
            end
        end
    end

    // Push one entry, then pop it, checking class and flags literally.
    task automatic push_pop(input logic [2:0] o, input logic [31:0] w,
                            input logic g, input logic l, input logic e_,
                            input logic [4:0] exp_cls, input logic [2:0] exp_cmp,
                            input string name);
        @(negedge clk);
        in_valid = 1; op = o; z = w; gr = g; ls = l; eq = e_;
        @(negedge clk);
        in_valid = 0; gr = 0; ls = 0; eq = 0;
        chk({name, "_class"}, 32'(out_class), 32'(exp_cls));
        chk({name, "_cmp"}, 32'(out_cmp), 32'(exp_cmp));
        chk({name, "_z"}, out_z, w);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk({name, "_drained"}, 32'(count), 32'd0);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1);
    end

    initial begin
        // reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_z", out_z, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // single push then pop
        @(negedge clk);
        in_valid = 1; op = 3'b000; z = 32'h3F800000;
        @(negedge clk);
        in_valid = 0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_z", out_z, 32'h3F800000);
        chk("single_class", 32'(out_class), 32'd0);
        chk("single_cmp", 32'(out_cmp), 32'd0);
        chk("single_count", 32'(count), 32'd1);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("single_pop_count", 32'(count), 32'd0);
        chk("single_pop_valid", 32'(out_valid), 32'd0);

        // classification sweep
        push_pop(3'b011, 32'h7FC00000, 0, 0, 0, 5'b01000, 3'b000, "nan");
        push_pop(3'b010, 32'hFF800000, 0, 0, 0, 5'b00100, 3'b000, "inf");
        push_pop(3'b001, 32'h80000000, 0, 0, 0, 5'b00010, 3'b000, "negzero");
        push_pop(3'b000, 32'h00000001, 0, 0, 0, 5'b00001, 3'b000, "subnorm");
        push_pop(3'b110, 32'h7F800000, 0, 0, 0, 5'b10000, 3'b000, "illegal");
        push_pop(3'b000, 32'h3FC00000, 0, 0, 0, 5'b00000, 3'b000, "normal");
        // compare entry keeps flags; arithmetic entry drops them
        push_pop(3'b100, 32'h00000000, 0, 1, 0, 5'b00000, 3'b010, "cmp");
        push_pop(3'b000, 32'h3F800000, 1, 0, 0, 5'b00000, 3'b000, "addflags");

        // fill to full
        out_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            in_valid = 1; op = 3'b000; z = 32'(i);
        end
        @(negedge clk);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        z = 32'd5; out_ready = 1;               // in_valid still 1
        @(negedge clk);
        out_ready = 0;
        chk("full_pop_only_count", 32'(count), 32'd3);
        chk("full_pop_only_head", out_z, 32'd2);
        @(negedge clk);
        in_valid = 0;
        chk("full_refill_count", 32'(count), 32'd4);
        out_ready = 1;
        for (int i = 2; i <= 5; i++) begin
            chk("drain_order", out_z, 32'(i));
            @(negedge clk);
        end
        out_ready = 0;
        chk("drain_empty", 32'(count), 32'd0);

        // streaming with pointer wrap
        in_valid = 1; out_ready = 1; op = 3'b000;
        for (int i = 0; i < 20; i++) begin
            z = 32'(i);
            @(negedge clk);
            chk("stream_count", 32'(count), 32'd1);
            chk("stream_z", out_z, 32'(i));
        end
        in_valid = 0;
        @(negedge clk);
        out_ready = 0;
        chk("stream_end_count", 32'(count), 32'd0);

        // asynchronous reset mid-operation
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            z = 32'h100 + 32'(i);
            @(negedge clk);
        end
        in_valid = 0;
        chk("pre_reset_count", 32'(count), 32'd3);
        #2 rst_n = 0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post_reset_empty", 32'(out_valid), 32'd0);
        in_valid = 1; z = 32'hAAAA5555; op = 3'b000;
        @(negedge clk);
        in_valid = 0;
        chk("post_reset_count", 32'(count), 32'd1);
        chk("post_reset_z", out_z, 32'hAAAA5555);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("post_reset_drained", 32'(count), 32'd0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
